// File: rtl/reflet_mailbox_if.sv
// reflet_mailbox_if: CPU bus responder signals plus the TX/RX byte stream pair.
// The slave modport is the mailbox; the master modport is the CPU/stream side.
interface reflet_mailbox_if #(
  parameter int unsigned wordsize       = 8,
  parameter int unsigned base_addr_size = 6
);
  // CPU bus
  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic [wordsize-1:0]       data_in;
  logic [wordsize-1:0]       data_out;
  logic                      write_en;
  logic                      irq;
  // TX stream (mailbox -> outside)
  logic [7:0]                out_data;
  logic                      out_valid;
  logic                      out_ready;
  // RX stream (outside -> mailbox)
  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (
    output enable, addr, data_in, write_en, out_ready, in_data, in_valid,
    input  data_out, irq, out_data, out_valid, in_ready
  );

  modport slave (
    input  enable, addr, data_in, write_en, out_ready, in_data, in_valid,
    output data_out, irq, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/reflet_mailbox.sv
// reflet_mailbox: CPU-bus mailbox bridging two byte FIFOs to a valid/ready stream pair.
// Offsets: 0 DATA (read pops RX, write pushes TX), 1 STATUS, 2 CTRL.
// Optional sticky error flags (STATUS b4/b5, CTRL b7 clear) under REFLET_MAILBOX_ERR_FLAGS_EN.
module reflet_mailbox #(
  parameter int unsigned               wordsize       = 8,
  parameter int unsigned               base_addr_size = 6,
  parameter logic [base_addr_size-1:0] base_addr      = 6'h28,
  parameter int unsigned               depth_log2     = 3
) (
  input logic             clk,
  input logic             reset,
  reflet_mailbox_if.slave bus
);

  localparam int unsigned         depth   = 1 << depth_log2;
  localparam logic [depth_log2:0] ptr_one = 1;

  logic [7:0]          tx_mem [depth];
  logic [7:0]          rx_mem [depth];
  logic [depth_log2:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic                ie_rx, ie_tx;
  logic                rd_prev, wr_prev, ctrl_prev;

  logic [base_addr_size-1:0] off;
  logic       sel_data, sel_status, sel_ctrl;
  logic       rd_term, wr_term, ctrl_term;
  logic       rd_edge, wr_edge, ctrl_edge;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       flush_rx, flush_tx;
  logic [1:0] err_bits;
  logic       err_irq;
  logic [7:0] status, rd_data;

  // Address decode relative to the mailbox window
  assign off        = bus.addr - base_addr;
  assign sel_data   = bus.enable && (off == base_addr_size'(0));
  assign sel_status = bus.enable && (off == base_addr_size'(1));
  assign sel_ctrl   = bus.enable && (off == base_addr_size'(2));

  assign rd_term   = sel_data && !bus.write_en;
  assign wr_term   = sel_data && bus.write_en;
  assign ctrl_term = sel_ctrl && bus.write_en;

  // Only the first cycle of a held bus access has side effects
  assign rd_edge   = rd_term && !rd_prev;
  assign wr_edge   = wr_term && !wr_prev;
  assign ctrl_edge = ctrl_term && !ctrl_prev;

  assign tx_empty = (tx_wr == tx_rd);
  assign rx_empty = (rx_wr == rx_rd);
  assign tx_full  = (tx_wr[depth_log2] != tx_rd[depth_log2]) &&
                    (tx_wr[depth_log2-1:0] == tx_rd[depth_log2-1:0]);
  assign rx_full  = (rx_wr[depth_log2] != rx_rd[depth_log2]) &&
                    (rx_wr[depth_log2-1:0] == rx_rd[depth_log2-1:0]);

  // All full/empty qualifiers use the state before the edge
  assign tx_push  = wr_edge && !tx_full;
  assign tx_pop   = !tx_empty && bus.out_ready;
  assign rx_push  = bus.in_valid && bus.in_ready;
  assign rx_pop   = rd_edge && !rx_empty;
  assign flush_rx = ctrl_edge && bus.data_in[2];
  assign flush_tx = ctrl_edge && bus.data_in[3];

  assign bus.out_valid = !tx_empty;
  assign bus.out_data  = tx_mem[tx_rd[depth_log2-1:0]];
  assign bus.in_ready  = !rx_full && !reset;

`ifdef REFLET_MAILBOX_ERR_FLAGS_EN
  logic tx_overflow, rx_underflow;
  logic clear_err;

  assign clear_err = ctrl_edge && bus.data_in[7];

  // Sticky error flags; a set in the same edge as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (wr_edge && tx_full)       tx_overflow <= 1'b1;
      else if (clear_err)           tx_overflow <= 1'b0;
      if (rd_edge && rx_empty)      rx_underflow <= 1'b1;
      else if (clear_err)           rx_underflow <= 1'b0;
    end
  end

  assign err_bits = {rx_underflow, tx_overflow};
  assign err_irq  = (ie_rx || ie_tx) && (tx_overflow || rx_underflow);
`else
  assign err_bits = 2'b00;
  assign err_irq  = 1'b0;
`endif

  assign status  = {2'b00, err_bits, tx_full, tx_empty, rx_full, !rx_empty};
  assign bus.irq = (ie_rx && !rx_empty) || (ie_tx && tx_empty) || err_irq;

  // TX pointers; flush overrides any push/pop in the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else if (flush_tx) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + ptr_one;
      if (tx_pop)  tx_rd <= tx_rd + ptr_one;
    end
  end

  // RX pointers; flush overrides any push/pop in the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else if (flush_rx) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + ptr_one;
      if (rx_pop)  rx_rd <= rx_rd + ptr_one;
    end
  end

  // FIFO storage, contents are not reset
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[depth_log2-1:0]] <= bus.data_in[7:0];
    if (rx_push) rx_mem[rx_wr[depth_log2-1:0]] <= bus.in_data;
  end

  // Interrupt enables and previous-cycle access terms for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_rx     <= 1'b0;
      ie_tx     <= 1'b0;
      rd_prev   <= 1'b0;
      wr_prev   <= 1'b0;
      ctrl_prev <= 1'b0;
    end else begin
      if (ctrl_term) begin
        ie_rx <= bus.data_in[0];
        ie_tx <= bus.data_in[1];
      end
      rd_prev   <= rd_term;
      wr_prev   <= wr_term;
      ctrl_prev <= ctrl_term;
    end
  end

  // Zero-wait read mux; zero when not selected
  always_comb begin
    rd_data = 8'h00;
    if (sel_data)        rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd[depth_log2-1:0]];
    else if (sel_status) rd_data = status;
    else if (sel_ctrl)   rd_data = {6'b000000, ie_tx, ie_rx};
  end

  // Zero-extend the byte register view onto the CPU bus
  always_comb begin
    bus.data_out      = '0;
    bus.data_out[7:0] = rd_data;
  end

endmodule

// File: tb/tb_reflet_mailbox.sv
// tb_reflet_mailbox: directed test-plan sequences plus random traffic, checked by a
// queue-based reference model and a negedge monitor scoreboard.
module tb_reflet_mailbox;
  localparam logic [5:0] base = 6'h28;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reflet_mailbox_if #(.wordsize(8), .base_addr_size(6)) bus ();

  reflet_mailbox #(
    .wordsize(8), .base_addr_size(6), .base_addr(6'h28), .depth_log2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: FIFOs as queues, registers as plain bits
  byte unsigned m_tx[$];
  byte unsigned m_rx[$];
  bit m_ie_rx, m_ie_tx, m_ovf, m_unf;
  bit m_prev_rd, m_prev_wr, m_prev_ctrl;

  // Scoreboard queues consumed by the monitor
  typedef struct packed { logic irq; logic out_valid; logic in_ready; } flags_t;
  flags_t       exp_flags[$];
  byte unsigned exp_rd[$];
  byte unsigned exp_tx[$];

  // Snapshot of DUT outputs at the negedge of the last driven cycle
  logic [7:0] last_dout, last_odata;
  logic       last_irq, last_ovalid, last_iready;

  function automatic bit err_en();
`ifdef REFLET_MAILBOX_ERR_FLAGS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic byte unsigned m_status();
    byte unsigned s;
    s = 0;
    if (m_rx.size() != 0) s |= 8'h01;
    if (m_rx.size() == 8) s |= 8'h02;
    if (m_tx.size() == 0) s |= 8'h04;
    if (m_tx.size() == 8) s |= 8'h08;
    if (err_en() && m_ovf) s |= 8'h10;
    if (err_en() && m_unf) s |= 8'h20;
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_ie_rx && m_rx.size() != 0) || (m_ie_tx && m_tx.size() == 0) ||
           (err_en() && (m_ie_rx || m_ie_tx) && (m_ovf || m_unf));
  endfunction

  function automatic byte unsigned m_read(input logic [5:0] off);
    case (off)
      6'd0:    return (m_rx.size() != 0) ? m_rx[0] : 8'h00;
      6'd1:    return m_status();
      6'd2:    return {6'b0, m_ie_tx, m_ie_rx};
      default: return 8'h00;
    endcase
  endfunction

  // Apply the effect of one clock edge given the inputs that were held before it
  function automatic void m_edge(input bit en, input logic [5:0] a, input bit we,
                                 input byte unsigned d, input bit ordy, input bit ivld,
                                 input byte unsigned idat);
    logic [5:0] off;
    bit rd_t, wr_t, ct_t, strobe, tx_push, tx_pop, rx_push, rx_pop;
    int tx_n, rx_n;
    off  = a - base;
    rd_t = en && off == 0 && !we;
    wr_t = en && off == 0 && we;
    ct_t = en && off == 2 && we;
    tx_n = m_tx.size();
    rx_n = m_rx.size();
    tx_push = wr_t && !m_prev_wr && tx_n < 8;
    tx_pop  = tx_n > 0 && ordy;
    rx_push = ivld && rx_n < 8;
    rx_pop  = rd_t && !m_prev_rd && rx_n > 0;
    strobe  = ct_t && !m_prev_ctrl;
    if (wr_t && !m_prev_wr && tx_n == 8) m_ovf = 1;
    else if (strobe && d[7])              m_ovf = 0;
    if (rd_t && !m_prev_rd && rx_n == 0) m_unf = 1;
    else if (strobe && d[7])              m_unf = 0;
    if (strobe && d[3]) begin
      m_tx.delete();
      exp_tx.delete();
    end else begin
      if (tx_pop) void'(m_tx.pop_front());
      if (tx_push) begin
        m_tx.push_back(d);
        exp_tx.push_back(d);
      end
    end
    if (strobe && d[2]) m_rx.delete();
    else begin
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_push) m_rx.push_back(idat);
    end
    if (ct_t) begin
      m_ie_rx = d[0];
      m_ie_tx = d[1];
    end
    m_prev_rd   = rd_t;
    m_prev_wr   = wr_t;
    m_prev_ctrl = ct_t;
  endfunction

  function automatic void m_clear();
    m_tx.delete(); m_rx.delete(); exp_tx.delete(); exp_rd.delete(); exp_flags.delete();
    m_ie_rx = 0; m_ie_tx = 0; m_ovf = 0; m_unf = 0;
    m_prev_rd = 0; m_prev_wr = 0; m_prev_ctrl = 0;
  endfunction

  // One bus/stream cycle, entered and left at posedge+1
  task automatic cycle(input bit en, input logic [5:0] a, input bit we, input byte unsigned d,
                       input bit ordy, input bit ivld, input byte unsigned idat);
    bus.enable = en; bus.addr = a; bus.write_en = we; bus.data_in = d;
    bus.out_ready = ordy; bus.in_valid = ivld; bus.in_data = idat;
    exp_flags.push_back('{irq: m_irq(), out_valid: (m_tx.size() != 0),
                          in_ready: (m_rx.size() < 8)});
    if (en && !we) exp_rd.push_back(m_read(a - base));
    @(negedge clk);
    last_dout = bus.data_out; last_odata = bus.out_data; last_irq = bus.irq;
    last_ovalid = bus.out_valid; last_iready = bus.in_ready;
    @(posedge clk);
    m_edge(en, a, we, d, ordy, ivld, idat);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 6'h00, 1'b0, 8'h00, ordy, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [5:0] off, input byte unsigned d);
    cycle(1'b1, base + off, 1'b1, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [5:0] off);
    cycle(1'b1, base + off, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_rx(input byte unsigned b);
    cycle(1'b0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b1, b);
  endtask

  // Asynchronous reset pulse asserted mid-cycle with an RX transfer in flight
  task automatic do_reset();
    mon_on = 0;
    bus.enable = 0; bus.write_en = 0; bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 8'hEE;
    #2 reset = 1;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_irq", bus.irq, 0);
    m_clear();
    @(posedge clk);
    #3 reset = 0;
    bus.in_valid = 0;
    @(posedge clk);
    #1 mon_on = 1;
  endtask

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin : monitor
    flags_t f;
    if (mon_on) begin
      if (exp_flags.size() == 0) check("flags_queue_empty", 1, 0);
      else begin
        f = exp_flags.pop_front();
        check("irq", bus.irq, f.irq);
        check("out_valid", bus.out_valid, f.out_valid);
        check("in_ready", bus.in_ready, f.in_ready);
      end
      if (bus.enable && !bus.write_en) begin
        if (exp_rd.size() == 0) check("rd_queue_empty", 1, 0);
        else check("data_out", bus.data_out, exp_rd.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_tx.size() == 0) check("tx_unexpected", bus.out_data, 9'h100);
        else check("out_data", bus.out_data, exp_tx.pop_front());
      end
    end
  end

  initial begin
    bus.enable = 0; bus.addr = 0; bus.write_en = 0; bus.data_in = 0;
    bus.out_ready = 0; bus.in_valid = 0; bus.in_data = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #3 reset = 0;
    @(posedge clk);
    #1 mon_on = 1;

    // Reset state
    rd(1);
    check("reset_status", last_dout, 8'h04);
    check("reset_irq", last_irq, 0);
    check("reset_out_valid", last_ovalid, 0);
    check("reset_in_ready", last_iready, 1);

    // Held write pushes exactly one byte
    repeat (3) wr(0, 8'hA5);
    idle(0);
    check("tx_one_valid", last_ovalid, 1);
    check("tx_one_data", last_odata, 8'hA5);
    rd(1);
    check("tx_one_status", last_dout, 8'h00);
    idle(1);
    idle(0);
    check("tx_drained", last_ovalid, 0);

    // Fill RX from the stream, then read it back
    for (int i = 0; i < 8; i++) push_rx(8'h10 + i);
    idle(0);
    check("rx_full_in_ready", last_iready, 0);
    rd(1);
    check("rx_full_status", last_dout, 8'h07);
    for (int i = 0; i < 8; i++) begin
      rd(0);
      check("rx_read_order", last_dout, 8'h10 + i);
      idle(0);
    end
    rd(0);
    check("rx_empty_read", last_dout, 8'h00);
    idle(0);
    wr(2, 8'h80);

    // RX interrupt
    wr(2, 8'h01);
    idle(0);
    check("irq_rx_empty", last_irq, 0);
    push_rx(8'h42);
    idle(0);
    check("irq_rx_set", last_irq, 1);
    rd(0);
    check("irq_rx_data", last_dout, 8'h42);
    idle(0);
    check("irq_rx_clear", last_irq, 0);

    // TX overflow with a same-cycle stream pop
    for (int i = 0; i < 8; i++) begin
      wr(0, 8'h30 + i);
      idle(0);
    end
    cycle(1'b1, base, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);
    idle(0);
    rd(1);
    check("ovf_status", last_dout, err_en() ? 8'h10 : 8'h00);
    repeat (7) idle(1);
    idle(0);
    check("ovf_seven_left", last_ovalid, 0);
    wr(2, 8'h80);
    rd(1);
    check("ovf_cleared_status", last_dout, 8'h04);

    // Reset mid stream transfer, then flush beating a stream push
    wr(0, 8'h5A);
    wr(2, 8'h03);
    for (int i = 0; i < 3; i++) push_rx(8'h60 + i);
    do_reset();
    rd(1);
    check("post_reset_status", last_dout, 8'h04);
    push_rx(8'h70);
    push_rx(8'h71);
    wr(0, 8'h72);
    idle(0);
    cycle(1'b1, base + 6'd2, 1'b1, 8'h0C, 1'b0, 1'b1, 8'h73);
    rd(1);
    check("flush_status", last_dout, 8'h04);

    // Random traffic with held accesses
    begin
      bit en = 0, we = 0;
      logic [5:0] a = 0;
      byte unsigned d = 0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          en = ($urandom_range(0, 4) != 0);
          a  = base - 6'd1 + 6'($urandom_range(0, 4));
          we = $urandom_range(0, 1);
          d  = 8'($urandom);
          if (a == base + 6'd2 && $urandom_range(0, 7) != 0) d[3:2] = 2'b00;
        end
        cycle(en, a, we, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom));
      end
    end

    mon_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
